// File: rtl/sta_pkg.sv
// Shared types and constants for the STA stimulus/collect engine.
package sta_pkg;

  localparam int unsigned N_NODE  = 16;
  localparam int unsigned N_EDGE  = 32;
  localparam int unsigned TIMEOUT = 4096;

  typedef logic [3:0] node_t;
  typedef logic [3:0] delay_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_FIN
  } sta_state_t;

endpackage

// File: rtl/sta_path_buf.sv
// Critical-path capture buffer: 16x4 register file with an append pointer,
// synchronous clear, full flag and an asynchronous read port.
module sta_path_buf
  import sta_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [4:0] len,
  output logic       full
);

  node_t mem [N_NODE];

  assign full    = (len == 5'(N_NODE));
  assign rd_data = mem[rd_addr];

  // Append at the pointer until full; writes while full are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_NODE; i++) begin
        mem[i] <= '0;
      end
      len <= '0;
    end else if (clr) begin
      len <= '0;
    end else if (wr_en && !full) begin
      mem[len[3:0]] <= wr_data;
      len           <= len + 5'd1;
    end
  end

endmodule

// File: rtl/sta_stim_tx.sv
// STA core stimulus transmitter and result collector.
// Streams a 16-node / 32-edge timing graph to the core, then captures the
// worst delay and critical path from the core's result burst.
// Optional watchdog on WAIT/RECV enabled by `define STA_STIM_TX_TIMEOUT_EN.
module sta_stim_tx #(
  parameter int unsigned N_NODE  = sta_pkg::N_NODE,
  parameter int unsigned N_EDGE  = sta_pkg::N_EDGE,
  parameter int unsigned TIMEOUT = sta_pkg::TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic       cfg_sel,
  input  logic [4:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       in_valid,
  output logic [3:0] delay,
  output logic [3:0] source,
  output logic [3:0] destination,
  input  logic       out_valid,
  input  logic [7:0] worst_delay,
  input  logic [3:0] path,
  output logic [7:0] res_delay,
  output logic [4:0] res_len,
  input  logic [3:0] res_rd_addr,
  output logic [3:0] res_node
);

  import sta_pkg::*;

  delay_t     delay_tab [N_NODE];
  logic [7:0] edge_tab  [N_EDGE];

  sta_state_t state, state_d;
  logic [4:0] k, k_d, k_nxt;
  logic       iv_d, busy_d, done_d, err_d;
  logic [3:0] delay_d, src_d, dst_d;
  logic [7:0] res_delay_d;
  logic       first_bad, first_bad_d;
  node_t      last_node, last_node_d;
  logic       buf_clr, buf_we, buf_full;
  logic       tab_we, wd_hit;
  delay_t     first_delay;
  logic [7:0] first_edge, nxt_edge;
  delay_t     nxt_delay;

  // Host writes land only while the engine is not busy.
  assign tab_we = cfg_we & ~busy;

  // Graph tables; contents are not reset.
  always_ff @(posedge clk) begin
    if (tab_we) begin
      if (!cfg_sel && !cfg_addr[4]) delay_tab[cfg_addr[3:0]] <= cfg_data[3:0];
      if (cfg_sel) edge_tab[cfg_addr] <= cfg_data;
    end
  end

  // Entry 0 is forwarded from a same-cycle write so launch sees the new value.
  always_comb begin
    first_delay = delay_tab[0];
    first_edge  = edge_tab[0];
    if (tab_we && cfg_addr == 5'd0) begin
      if (cfg_sel) first_edge  = cfg_data;
      else         first_delay = cfg_data[3:0];
    end
  end

  assign k_nxt     = k + 5'd1;
  assign nxt_edge  = edge_tab[k_nxt];
  assign nxt_delay = k_nxt[4] ? '0 : delay_tab[k_nxt[3:0]];

`ifdef STA_STIM_TX_TIMEOUT_EN
  localparam logic [11:0] WD_LAST = 12'(TIMEOUT - 1);
  logic [11:0] wd;

  // Watchdog counts cycles spent waiting on or receiving the core result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  wd <= '0;
    else if (state == ST_SEND)                   wd <= '0;
    else if (state == ST_WAIT || state == ST_RECV) wd <= wd + 12'd1;
  end

  assign wd_hit = (state == ST_WAIT || state == ST_RECV) && (wd == WD_LAST);
`else
  assign wd_hit = 1'b0;
  // TIMEOUT only takes effect in the watchdog build.
  if (TIMEOUT == 0) begin : g_no_watchdog
  end
`endif

  // Next-state and next-output logic; all outputs are registered from here.
  always_comb begin
    state_d     = state;
    k_d         = k;
    iv_d        = 1'b0;
    delay_d     = '0;
    src_d       = '0;
    dst_d       = '0;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = err;
    res_delay_d = res_delay;
    first_bad_d = first_bad;
    last_node_d = last_node;
    buf_clr     = 1'b0;
    buf_we      = 1'b0;
    case (state)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d     = ST_SEND;
          k_d         = '0;
          iv_d        = 1'b1;
          delay_d     = first_delay;
          src_d       = first_edge[7:4];
          dst_d       = first_edge[3:0];
          busy_d      = 1'b1;
          err_d       = 1'b0;
          res_delay_d = '0;
          buf_clr     = 1'b1;
        end
      end
      ST_SEND: begin
        if (k == 5'(N_EDGE - 1)) begin
          state_d = ST_WAIT;
        end else begin
          k_d     = k_nxt;
          iv_d    = 1'b1;
          delay_d = nxt_delay;
          src_d   = nxt_edge[7:4];
          dst_d   = nxt_edge[3:0];
        end
      end
      ST_WAIT: begin
        if (out_valid) begin
          state_d     = ST_RECV;
          res_delay_d = worst_delay;
          buf_we      = 1'b1;
          first_bad_d = (path != 4'd0);
          last_node_d = path;
        end
      end
      ST_RECV: begin
        if (out_valid) begin
          if (buf_full) begin
            err_d = 1'b1;
          end else begin
            buf_we      = 1'b1;
            last_node_d = path;
          end
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = err | first_bad | (last_node != 4'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Watchdog expiry wins over any result traffic in the same cycle.
    if (wd_hit) begin
      state_d     = ST_FIN;
      done_d      = 1'b1;
      busy_d      = 1'b0;
      err_d       = 1'b1;
      res_delay_d = res_delay;
      buf_we      = 1'b0;
      last_node_d = last_node;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      in_valid    <= 1'b0;
      delay       <= '0;
      source      <= '0;
      destination <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      res_delay   <= '0;
      first_bad   <= 1'b0;
      last_node   <= '0;
    end else begin
      k           <= k_d;
      in_valid    <= iv_d;
      delay       <= delay_d;
      source      <= src_d;
      destination <= dst_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      res_delay   <= res_delay_d;
      first_bad   <= first_bad_d;
      last_node   <= last_node_d;
    end
  end

  sta_path_buf u_path_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (buf_clr),
    .wr_en   (buf_we),
    .wr_data (path),
    .rd_addr (res_rd_addr),
    .rd_data (res_node),
    .len     (res_len),
    .full    (buf_full)
  );

endmodule

// File: tb/tb_sta_stim_tx.sv
// Randomized self-checking bench for sta_stim_tx against a transaction-level model.
module tb_sta_stim_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [4:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       start = 1'b0;
  logic       busy, done, err, in_valid;
  logic [3:0] delay, source, destination;
  logic       out_valid = 1'b0;
  logic [7:0] worst_delay = '0;
  logic [3:0] path = '0;
  logic [7:0] res_delay;
  logic [4:0] res_len;
  logic [3:0] res_rd_addr = '0;
  logic [3:0] res_node;

  sta_stim_tx #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .busy(busy),
    .done(done), .err(err), .in_valid(in_valid), .delay(delay),
    .source(source), .destination(destination), .out_valid(out_valid),
    .worst_delay(worst_delay), .path(path), .res_delay(res_delay),
    .res_len(res_len), .res_rd_addr(res_rd_addr), .res_node(res_node)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host-side copy of the graph tables and the snapshot a launch streams from.
  logic [3:0] m_delay [16];
  logic [7:0] m_edge  [32];
  logic [3:0] s_delay [16];
  logic [7:0] s_edge  [32];

  // Expected transaction: launch cycle, completion cycle, captured results.
  bit         active = 1'b0;
  int         s_cyc = 0, done_cyc = 0, e_len = 0;
  logic [7:0] e_wd = '0;
  bit         e_err = 1'b0;
  logic [3:0] e_path [16];

  // Plan for the core's response and host disturbances.
  int         p_n = 0, p_gap = 0;
  logic [3:0] p_path [24];
  logic [7:0] p_wd = '0;
  bit         p_noise = 0, p_disturb = 0, p_samecfg = 0, p_midrst = 0;

  // Compare every DUT output against the model each cycle out of reset.
  always @(negedge clk) begin
    int idx;
    bit iv, eb;
    logic [3:0] ed, es, edst;
    if (rst_n) begin
      idx  = cyc - s_cyc - 1;
      iv   = active && idx >= 0 && idx < 32;
      ed   = '0;
      es   = '0;
      edst = '0;
      if (iv) begin
        ed   = (idx < 16) ? s_delay[idx] : 4'd0;
        es   = s_edge[idx][7:4];
        edst = s_edge[idx][3:0];
      end
      eb = active && cyc > s_cyc && cyc < done_cyc;
      chk("in_valid", in_valid, iv);
      chk("delay", delay, ed);
      chk("source", source, es);
      chk("destination", destination, edst);
      chk("busy", busy, eb);
      chk("done", done, active && cyc == done_cyc);
      if (!active) begin
        chk("idle_err", err, 0);
        chk("idle_res_delay", res_delay, 0);
        chk("idle_res_len", res_len, 0);
        chk("idle_res_node", res_node, 0);
      end else if (iv) begin
        chk("send_err", err, 0);
        chk("send_res_len", res_len, 0);
        chk("send_res_delay", res_delay, 0);
      end else if (cyc >= done_cyc) begin
        chk("err", err, e_err);
        chk("res_delay", res_delay, e_wd);
        chk("res_len", res_len, e_len);
        if (int'(res_rd_addr) < e_len) chk("res_node", res_node, e_path[res_rd_addr]);
      end
    end
  end

  task automatic wr(input bit sel, input int addr, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = 5'(addr);
    cfg_data = d;
    if (sel) m_edge[addr] = d;
    else     m_delay[addr] = d[3:0];
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) wr(1'b0, i, 8'($urandom));
    for (int i = 0; i < 32; i++) wr(1'b1, i, 8'($urandom));
  endtask

  task automatic plan_random(input bit good);
    int len;
    p_n   = 1 + int'($urandom_range(19));
    p_gap = int'($urandom_range(10));
    p_wd  = 8'($urandom);
    for (int i = 0; i < 24; i++) p_path[i] = 4'($urandom);
    len = (p_n > 16) ? 16 : p_n;
    if (good) begin
      p_path[0]     = 4'd0;
      p_path[len-1] = 4'd1;
    end
  endtask

  task automatic run();
    int v0, len, c;
    start = 1'b1;
    if (p_samecfg) begin
      cfg_we   = 1'b1;
      cfg_sel  = 1'($urandom);
      cfg_addr = '0;
      cfg_data = 8'($urandom);
      if (cfg_sel) m_edge[0] = cfg_data;
      else         m_delay[0] = cfg_data[3:0];
    end
    s_delay = m_delay;
    s_edge  = m_edge;
    s_cyc   = cyc;
    v0      = s_cyc + 33 + p_gap;
    len     = (p_n > 16) ? 16 : p_n;
    e_len   = len;
    if (p_n == 0) begin
      done_cyc = s_cyc + 33 + 64;
      e_wd     = '0;
      e_err    = 1'b1;
    end else begin
      done_cyc = v0 + p_n + 1;
      e_wd     = p_wd;
      e_err    = (p_n > 16) || (p_path[0] != 4'd0) || (p_path[len-1] != 4'd1);
    end
    for (int i = 0; i < 16; i++) e_path[i] = (i < len) ? p_path[i] : 4'd0;
    active = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    while (cyc < done_cyc + 3) begin
      c           = cyc;
      start       = 1'b0;
      cfg_we      = 1'b0;
      out_valid   = 1'b0;
      worst_delay = 8'($urandom);
      path        = 4'($urandom);
      res_rd_addr = 4'($urandom);
      if (p_disturb && c == s_cyc + 1) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_sel  = 1'b0;
        cfg_addr = 5'd2;
        cfg_data = {4'h0, ~m_delay[2]};
      end
      if (p_n > 0 && c >= v0 && c < v0 + p_n) begin
        out_valid = 1'b1;
        path      = p_path[c - v0];
        if (c == v0) worst_delay = p_wd;
      end else if (p_noise && c > s_cyc && c <= s_cyc + 32) begin
        out_valid = 1'($urandom);
      end
      if (p_midrst && c == s_cyc + 10) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_valid", in_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        active    = 1'b0;
        out_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        break;
      end
      tick();
    end
    start     = 1'b0;
    cfg_we    = 1'b0;
    out_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) e_path[i] = '0;
    repeat (3) tick();
    chk("rst_in_valid", in_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res_len", res_len, 0);
    chk("rst_res_delay", res_delay, 0);
    rst_n = 1'b1;
    tick();

    // Delays equal node index, random edges, path 0,5,9,1 with worst 37.
    for (int i = 0; i < 16; i++) wr(1'b0, i, 8'(i));
    for (int i = 0; i < 32; i++) wr(1'b1, i, 8'($urandom));
    p_n = 4; p_gap = 2; p_wd = 8'd37;
    p_path[0] = 4'd0; p_path[1] = 4'd5; p_path[2] = 4'd9; p_path[3] = 4'd1;
    run();
    res_rd_addr = 4'd2;
    #1;
    chk("dir_res_delay", res_delay, 37);
    chk("dir_res_len", res_len, 4);
    chk("dir_res_node2", res_node, 9);
    chk("dir_err", err, 0);

    // Overflow: 18 result cycles.
    plan_random(1'b1);
    p_n = 18; p_path[15] = 4'd1;
    run();
    chk("ovf_res_len", res_len, 16);
    chk("ovf_err", err, 1);

    // Bad first node.
    p_n = 3; p_gap = 0; p_wd = 8'd200;
    p_path[0] = 4'd3; p_path[1] = 4'd5; p_path[2] = 4'd1;
    run();
    res_rd_addr = 4'd0;
    #1;
    chk("bad_err", err, 1);
    chk("bad_res_len", res_len, 3);
    chk("bad_res_node0", res_node, 3);
    chk("bad_res_delay", res_delay, 200);

    // Start and table write during SEND, then a run with no reload.
    plan_random(1'b1);
    p_disturb = 1;
    run();
    p_disturb = 0;
    plan_random(1'b1);
    run();

    // Table write on the launch cycle.
    p_samecfg = 1;
    repeat (4) begin
      plan_random(1'b1);
      run();
    end
    p_samecfg = 0;

    // Randomized traffic.
    repeat (20) begin
      repeat ($urandom_range(8)) begin
        if ($urandom_range(1) == 0) wr(1'b0, int'($urandom_range(15)), 8'($urandom));
        else                        wr(1'b1, int'($urandom_range(31)), 8'($urandom));
      end
      plan_random($urandom_range(3) != 0);
      p_noise   = 1'($urandom);
      p_samecfg = 1'($urandom);
      run();
    end
    p_noise = 0;
    p_samecfg = 0;

    // Reset in the middle of the stream, then reload and run again.
    plan_random(1'b1);
    p_midrst = 1;
    run();
    p_midrst = 0;
    load_all();
    plan_random(1'b1);
    run();

`ifdef STA_STIM_TX_TIMEOUT_EN
    // No core response: watchdog ends the transaction.
    p_n = 0;
    run();
    chk("wd_err", err, 1);
    chk("wd_res_len", res_len, 0);
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
